// File: rtl/comparator_serial_param.sv
// comparator_serial_param
//
// Multi-cycle magnitude comparator. It compares two WIDTH-bit operands
// MSB-first, DIGIT bits per clock, and stops at the first digit that differs.
// A start/busy/done handshake controls it. All six relational flags are
// registered and are written together when the comparison completes.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   DIGIT  bits examined per compare cycle (1..WIDTH, must divide WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request, sampled only in IDLE or DONE
//   valA/valB  operands, captured when start is accepted
//   is_signed  (only with SIGNED_CMP_EN) two's-complement compare, captured on start
//   busy       high while comparing
//   done       one-cycle pulse, the flags are updated in this cycle
//   aGTb aGEb aLTb aLEb aEQb aNEb  registered relational flags
//
// Optional feature macro: SIGNED_CMP_EN adds the is_signed input.

module comparator_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
`ifdef SIGNED_CMP_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             aGTb,
    output logic             aGEb,
    output logic             aLTb,
    output logic             aLEb,
    output logic             aEQb,
    output logic             aNEb
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    // Stop elaboration if the digit does not tile the operand exactly.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("comparator_serial_param: invalid WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    assign dig_a = sh_a[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b[WIDTH-1 -: DIGIT];

    // A signed compare flips both sign bits. Two's-complement order then
    // matches unsigned order, so the serial engine needs no signed case.
    always_comb begin
        load_a = valA;
        load_b = valB;
`ifdef SIGNED_CMP_EN
        load_a[WIDTH-1] = valA[WIDTH-1] ^ is_signed;
        load_b[WIDTH-1] = valB[WIDTH-1] ^ is_signed;
`endif
    end

    // Control FSM and datapath. DONE accepts a new start just like IDLE,
    // so back-to-back operations have no idle cycle between them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            aGTb  <= 1'b0;
            aGEb  <= 1'b0;
            aLTb  <= 1'b0;
            aLEb  <= 1'b0;
            aEQb  <= 1'b0;
            aNEb  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= load_a;
                        sh_b  <= load_b;
                        cnt   <= CW'(N);
                        state <= COMPARE;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (dig_a != dig_b) begin
                        // The first differing digit decides the result.
                        aGTb  <= (dig_a > dig_b);
                        aGEb  <= (dig_a > dig_b);
                        aLTb  <= (dig_a < dig_b);
                        aLEb  <= (dig_a < dig_b);
                        aEQb  <= 1'b0;
                        aNEb  <= 1'b1;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt == CW'(1)) begin
                        aGTb  <= 1'b0;
                        aGEb  <= 1'b1;
                        aLTb  <= 1'b0;
                        aLEb  <= 1'b1;
                        aEQb  <= 1'b1;
                        aNEb  <= 1'b0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial_param.sv
// Testbench for comparator_serial_param (WIDTH=8, DIGIT=2). When
// SIGNED_CMP_EN is defined, it also exercises signed compares on the main
// instance and on a second WIDTH=6, DIGIT=3 instance.

module tb_comparator_serial_param;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;
    localparam int MAX_WAIT = 40;

    localparam logic [5:0] F_EQ = 6'b010110;
    localparam logic [5:0] F_GT = 6'b110001;
    localparam logic [5:0] F_LT = 6'b001101;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] valA = '0;
    logic [W-1:0] valB = '0;
    logic         busy, done;
    logic         aGTb, aGEb, aLTb, aLEb, aEQb, aNEb;
    logic [5:0]   flags;

    assign flags = {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0] flags;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

`ifdef SIGNED_CMP_EN
    logic is_signed = 1'b0;

    logic       start6 = 1'b0;
    logic [5:0] val_a6 = '0;
    logic [5:0] val_b6 = '0;
    logic       sgn6 = 1'b0;
    logic       busy6, done6;
    logic       gt6, ge6, lt6, le6, eq6, ne6;
    logic [5:0] flags6;

    assign flags6 = {gt6, ge6, lt6, le6, eq6, ne6};
`endif

    comparator_serial_param #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .valA      (valA),
        .valB      (valB),
`ifdef SIGNED_CMP_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .aGTb      (aGTb),
        .aGEb      (aGEb),
        .aLTb      (aLTb),
        .aLEb      (aLEb),
        .aEQb      (aEQb),
        .aNEb      (aNEb)
    );

`ifdef SIGNED_CMP_EN
    comparator_serial_param #(.WIDTH(6), .DIGIT(3)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .start     (start6),
        .valA      (val_a6),
        .valB      (val_b6),
        .is_signed (sgn6),
        .busy      (busy6),
        .done      (done6),
        .aGTb      (gt6),
        .aGEb      (ge6),
        .aLTb      (lt6),
        .aLEb      (le6),
        .aEQb      (eq6),
        .aNEb      (ne6)
    );
`endif

    always #5 clk = ~clk;

    // Reference model. The flags come from a direct relational compare. The
    // latency is the index of the first differing digit, counted from the MSB.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t         e;
        logic [W-1:0] ma, mb;
        logic         gt;
        logic         found;
        ma = a;
        mb = b;
        if (sgn) begin
            ma[W-1] = ~ma[W-1];
            mb[W-1] = ~mb[W-1];
        end
        gt    = sgn ? ($signed(a) > $signed(b)) : (a > b);
        e.lat = N;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && (ma[W-1-i*D -: D] != mb[W-1-i*D -: D])) begin
                e.lat = i + 1;
                found = 1'b1;
            end
        end
        e.flags = (a == b) ? F_EQ : (gt ? F_GT : F_LT);
        return e;
    endfunction

    // Drive a request at a falling edge and record its expected result.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(negedge clk);
        valA  = a;
        valB  = b;
`ifdef SIGNED_CMP_EN
        is_signed = sgn;
`endif
        start = 1'b1;
        exp_q.push_back(model(a, b, sgn));
    endtask

    // Called at the falling edge after the accept edge. Counts rising edges
    // until done is seen, and notes whether busy stayed high while waiting.
    task automatic wait_done(output int cycles, output logic busy_ok);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!done && cycles < MAX_WAIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (flags !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000000", flags); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_done: got %b want 0", done); end
        n_checks++;
        if (flags !== 6'b0) begin n_fail++; $display("[TB] FAIL idle_flags: got %b want 000000", flags); end
    endtask

    task automatic test_equal();
        int   cyc;
        logic bok;
        exp_t e;
        drive_start(8'hA5, 8'hA5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL eq_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL eq_flags: got %b want %b", flags, e.flags); end
        n_checks++;
        if (bok !== 1'b1) begin n_fail++; $display("[TB] FAIL eq_busy: got %b want 1", bok); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || flags !== e.flags) begin
                n_fail++;
                $display("[TB] FAIL eq_hold[%0d]: got done=%b flags=%b want done=0 flags=%b", i, done, flags, e.flags);
            end
        end
    endtask

    task automatic test_early_and_late();
        int   cyc;
        logic bok;
        exp_t e;
        drive_start(8'h80, 8'h7F, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL gt_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL gt_flags: got %b want %b", flags, e.flags); end

        drive_start(8'h12, 8'h13, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (flags !== F_GT) begin n_fail++; $display("[TB] FAIL flags_hold_in_compare: got %b want %b", flags, F_GT); end
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL lt_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL lt_flags: got %b want %b", flags, e.flags); end
        n_checks++;
        if (bok !== 1'b1) begin n_fail++; $display("[TB] FAIL lt_busy: got %b want 1", bok); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic bok;
        exp_t e;
        drive_start(8'h80, 8'h7F, 1'b0);
        @(posedge clk);
        @(negedge clk);
        valA = 8'h00;
        valB = 8'hFF;
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL b2b_first_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL b2b_first_flags: got %b want %b", flags, e.flags); end
        exp_q.push_back(model(8'h00, 8'hFF, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL b2b_second_flags: got %b want %b", flags, e.flags); end
    endtask

    task automatic test_ignored_start();
        int   cyc;
        logic bok;
        exp_t e;
        drive_start(8'h12, 8'h13, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        valA  = 8'hFF;
        valB  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc + 1 !== e.lat) begin n_fail++; $display("[TB] FAIL ign_latency: got %0d want %0d", cyc + 1, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL ign_flags: got %b want %b", flags, e.flags); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ign_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int   cyc;
        logic bok;
        logic saw_done;
        exp_t e;
        drive_start(8'h12, 8'h13, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_status: got busy=%b done=%b want 0 0", busy, done);
        end
        n_checks++;
        if (flags !== 6'b0) begin n_fail++; $display("[TB] FAIL abort_flags: got %b want 000000", flags); end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %b want 0", saw_done); end

        drive_start(8'hA5, 8'hA4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bok);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL after_abort_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++;
        if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL after_abort_flags: got %b want %b", flags, e.flags); end
    endtask

`ifdef SIGNED_CMP_EN
    task automatic test_signed();
        int   cyc;
        logic bok;
        exp_t e;
        for (int s = 1; s >= 0; s--) begin
            drive_start(8'h80, 8'h01, s[0]);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            wait_done(cyc, bok);
            e = exp_q.pop_front();
            n_checks++;
            if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL signed%0d_latency: got %0d want %0d", s, cyc, e.lat); end
            n_checks++;
            if (flags !== e.flags) begin n_fail++; $display("[TB] FAIL signed%0d_flags: got %b want %b", s, flags, e.flags); end
        end

        // The 6-bit instance: 0x20 is -32 when signed and 32 when unsigned.
        for (int s = 1; s >= 0; s--) begin
            @(negedge clk);
            val_a6 = 6'h20;
            val_b6 = 6'h01;
            sgn6   = s[0];
            start6 = 1'b1;
            e.flags = s[0] ? F_LT : F_GT;
            e.lat   = 1;
            exp_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            start6 = 1'b0;
            cyc = 0;
            while (!done6 && cyc < MAX_WAIT) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (cyc !== e.lat) begin n_fail++; $display("[TB] FAIL w6_signed%0d_latency: got %0d want %0d", s, cyc, e.lat); end
            n_checks++;
            if (flags6 !== e.flags) begin n_fail++; $display("[TB] FAIL w6_signed%0d_flags: got %b want %b", s, flags6, e.flags); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal();
        test_early_and_late();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
`ifdef SIGNED_CMP_EN
        test_signed();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/comparator_serial_param.md
Name: comparator_serial_param

Overview:
- Parametrised, multi-cycle magnitude comparator: next generation of the team's 3-bit combinational comparator.
- Operands are WIDTH bits wide and compared MSB-first, DIGIT bits per clock.
- Comparison terminates early at the first differing digit.
- Uses a start/busy/done handshake and registers all six relational flags. Sits beside datapath units that need wide compares without a long combinational chain.

Parameters:
WIDTH, 8, operand width in bits; must be >= 1.
DIGIT, 2, bits examined per COMPARE cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise).
(derived) N = WIDTH/DIGIT, number of digits; counter width clog2(N+1).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
valA  input  WIDTH  operand A, captured on accepted start.
valB  input  WIDTH  operand B, captured on accepted start.
busy  output  1  high while in COMPARE.
done  output  1  one-cycle pulse; flags updated in this cycle.
aGTb  output  1  A > B
aGEb  output  1  A >= B
aLTb  output  1  A < B
aLEb  output  1  A <= B
aEQb  output  1  A == B
aNEb  output  1  A != B

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; all six flags=0; shift regs and counter=0.
- Flags stay 0 until the first completion; aNEb is 0 during this window, not the complement of aEQb.
- States: IDLE, COMPARE, DONE. busy=1 only in COMPARE; done=1 only in DONE.
- IDLE with start=1 at edge t: load shA=valA, shB=valB, cnt=N, go COMPARE. With start=0, stay.
- COMPARE, each edge: compare top DIGIT bits of shA and shB as unsigned values.
  - Digits differ: register GT (digitA>digitB) or LT, go DONE.
  - Digits equal, cnt==1: register EQ, go DONE.
  - Digits equal, cnt>1: shift both left by DIGIT, cnt-=1, stay.
- Latency: the first differing digit index k (1 = MSB digit), or k=N if all digits are equal. done goes high k cycles after the start edge.
- Flag encoding written at the DONE transition, atomic and mutually consistent:
  - GT: aGTb=1 aGEb=1 aNEb=1, others 0.
  - LT: aLTb=1 aLEb=1 aNEb=1, others 0.
  - EQ: aEQb=1 aGEb=1 aLEb=1, others 0.
- Flags hold their last result until the next completion or reset; they do not change during COMPARE.
- DONE lasts exactly one cycle.
  - start=1 in DONE: accepted like IDLE (back-to-back operation, no bubble), go COMPARE.
  - start=0 in DONE: go IDLE.
- start in COMPARE is ignored. Operand inputs may change freely after acceptance.
- DIGIT==WIDTH: every compare completes in 1 cycle.
- Reset during COMPARE aborts the operation; no done pulse; flags=0.

Optional Feature:
Macro SIGNED_CMP_EN.
- Defined: adds input port is_signed (1 bit, after valB), captured on accepted start.
  - is_signed=1: operands are two's complement. The MSB of both captured operands is inverted at load; the serial engine is unchanged.
  - is_signed=0: unsigned compare.
- Undefined: no is_signed port; all compares are unsigned.

Test Plan:
(WIDTH=8, DIGIT=2, N=4 unless noted)
- Assert reset with no clock edge -> busy=0, done=0, all six flags=0 immediately; release, idle 3 cycles -> unchanged.
- valA=0xA5, valB=0xA5, start 1 cycle -> busy for 4 cycles, done pulse 4 cycles after start edge; aEQb=aGEb=aLEb=1, others 0; flags hold for 5 further idle cycles.
- valA=0x80, valB=0x7F -> done 1 cycle after start; aGTb=aGEb=aNEb=1, others 0. Then valA=0x12, valB=0x13 -> done after 4 cycles, aLTb=aLEb=aNEb=1.
- Back-to-back and ignored start:
  - Start 0x80/0x7F, hold start=1 with valA=0x00, valB=0xFF through DONE -> second op accepted in DONE, done 1 cycle later, LT.
  - Start asserted during COMPARE with other operands -> no effect on the result.
- Start 0x12/0x13, assert reset after 2 cycles -> state IDLE, no done pulse, flags=0; the next op completes normally.
- SIGNED_CMP_EN defined, valA=0x80, valB=0x01:
  - is_signed=1 -> LT after 1 cycle.
  - is_signed=0 -> GT.
  - Repeat with WIDTH=6, DIGIT=3 (valA=0x20, valB=0x01) -> same results, 1 cycle.
